// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       alu_cond,
   output logic [1:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_src,
   output logic       ir_write,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       illegal_instr
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR,
      MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL
   } state_t;
   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       pc_write;
      logic       pc_src;
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       reg_write;
      logic [1:0] wb_sel;
   } ctl_t;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   state_t state_q, state_d;
   ctl_t   ctl_q;
   logic   known;
   // Moore control word for each state; anything not set stays 0
   function automatic ctl_t ctl_of(state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 2'b01; end
         DECODE: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.alu_op = 2'b01; end
         EXEC_R: begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; end
         EXEC_I: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
         ADDR:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b01; end
         MEM_RD: begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
         MEM_WR: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.i_or_d = 1'b1; end
         WB_ALU: c.reg_write = 1'b1;
         WB_MEM: begin c.reg_write = 1'b1; c.wb_sel = 2'b01; end
         BRANCH: begin c.alu_src_a = 2'b01; c.alu_op = 2'b11; c.pc_src = 1'b1; end
         JAL:    begin c.reg_write = 1'b1; c.wb_sel = 2'b10; c.pc_write = 1'b1; c.pc_src = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction
   assign known = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};
   // Next-state selection; memory states hold until mem_ready, unknown opcodes fall back to FETCH
   always_comb begin
      state_d = FETCH;
      case (state_q)
         IDLE:           state_d = FETCH;
         FETCH:          state_d = mem_ready ? DECODE : FETCH;
         DECODE:         state_d = opcode == OP_R ? EXEC_R :
                                   opcode == OP_I ? EXEC_I :
                                   (opcode == OP_LD || opcode == OP_ST) ? ADDR :
                                   opcode == OP_BR ? BRANCH :
                                   opcode == OP_JAL ? JAL : FETCH;
         EXEC_R, EXEC_I: state_d = WB_ALU;
         ADDR:           state_d = opcode == OP_ST ? MEM_WR : MEM_RD;
         MEM_RD:         state_d = mem_ready ? WB_MEM : MEM_RD;
         MEM_WR:         state_d = mem_ready ? FETCH : MEM_WR;
         default:        state_d = FETCH;
      endcase
   end
   // State and the control word of the state being entered are registered together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_of(state_d);
      end
   end
   assign alu_op        = ctl_q.alu_op;
   assign alu_src_a     = ctl_q.alu_src_a;
   assign alu_src_b     = ctl_q.alu_src_b;
   assign pc_src        = ctl_q.pc_src;
   assign mem_req       = ctl_q.mem_req;
   assign mem_we        = ctl_q.mem_we;
   assign i_or_d        = ctl_q.i_or_d;
   assign reg_write     = ctl_q.reg_write;
   assign wb_sel        = ctl_q.wb_sel;
   assign ir_write      = state_q == FETCH && mem_ready;
   assign pc_write      = ctl_q.pc_write || (state_q == FETCH && mem_ready);
   assign pc_write_cond = state_q == BRANCH && alu_cond;
   assign illegal_instr = state_q == DECODE && !known;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors for the multicycle control FSM
module tb_multicycle_control;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       mem_ready = 1'b0;
   logic       alu_cond = 1'b0;
   logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
   logic       pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, i_or_d, reg_write, illegal_instr;
   int         checks = 0;
   int         errors = 0;
   // {alu_op, alu_src_a, alu_src_b, {pw,pwc,pc_src,ir_write,mem_req,mem_we,i_or_d,reg_write}, wb_sel, illegal}
   localparam logic [16:0] ZERO    = 17'd0;
   localparam logic [16:0] F_WAIT  = {2'b01, 2'b00, 2'b01, 8'b00001000, 2'b00, 1'b0};
   localparam logic [16:0] F_RDY   = {2'b01, 2'b00, 2'b01, 8'b10011000, 2'b00, 1'b0};
   localparam logic [16:0] DEC     = {2'b01, 2'b10, 2'b10, 8'b00000000, 2'b00, 1'b0};
   localparam logic [16:0] DEC_ILL = {2'b01, 2'b10, 2'b10, 8'b00000000, 2'b00, 1'b1};
   localparam logic [16:0] EXR     = {2'b10, 2'b01, 2'b00, 8'b00000000, 2'b00, 1'b0};
   localparam logic [16:0] EXI     = {2'b00, 2'b01, 2'b10, 8'b00000000, 2'b00, 1'b0};
   localparam logic [16:0] ADR     = {2'b01, 2'b01, 2'b10, 8'b00000000, 2'b00, 1'b0};
   localparam logic [16:0] MRD     = {2'b00, 2'b00, 2'b00, 8'b00001010, 2'b00, 1'b0};
   localparam logic [16:0] MWR     = {2'b00, 2'b00, 2'b00, 8'b00001110, 2'b00, 1'b0};
   localparam logic [16:0] WBA     = {2'b00, 2'b00, 2'b00, 8'b00000001, 2'b00, 1'b0};
   localparam logic [16:0] WBM     = {2'b00, 2'b00, 2'b00, 8'b00000001, 2'b01, 1'b0};
   localparam logic [16:0] BR0     = {2'b11, 2'b01, 2'b00, 8'b00100000, 2'b00, 1'b0};
   localparam logic [16:0] BR1     = {2'b11, 2'b01, 2'b00, 8'b01100000, 2'b00, 1'b0};
   localparam logic [16:0] JALV    = {2'b00, 2'b00, 2'b00, 8'b10100001, 2'b10, 1'b0};
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
   wire [16:0] outs = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src, ir_write,
                       mem_req, mem_we, i_or_d, reg_write, wb_sel, illegal_instr};
   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_cond(alu_cond),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
      .mem_we(mem_we), .i_or_d(i_or_d), .reg_write(reg_write), .wb_sel(wb_sel),
      .illegal_instr(illegal_instr)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ex(input string tag, input logic [16:0] e);
      #1;
      chk(tag, outs, e);
   endtask
   initial begin
      tick(); tick();
      ex("rst_hold", ZERO);
      rst = 1'b0;
      ex("post_rst_idle", ZERO);
      tick(); ex("fetch_wait", F_WAIT);
      tick(); ex("fetch_wait2", F_WAIT);
      mem_ready = 1'b1; opcode = OP_R;
      ex("fetch_rdy", F_RDY);
      tick(); ex("r_decode", DEC);
      tick(); ex("r_exec", EXR);
      tick(); ex("r_wb", WBA);
      tick(); ex("r_fetch", F_RDY);
      opcode = OP_LD;
      tick(); ex("ld_decode", DEC);
      tick(); mem_ready = 1'b0; ex("ld_addr", ADR);
      tick(); ex("ld_mem_w1", MRD);
      tick(); ex("ld_mem_w2", MRD);
      tick(); ex("ld_mem_w3", MRD);
      tick(); mem_ready = 1'b1; ex("ld_mem_rdy", MRD);
      tick(); ex("ld_wb", WBM);
      tick(); ex("ld_fetch", F_RDY);
      opcode = OP_ST;
      tick(); ex("st_decode", DEC);
      tick(); mem_ready = 1'b0; ex("st_addr", ADR);
      tick(); ex("st_mem_w1", MWR);
      tick(); mem_ready = 1'b1; ex("st_mem_rdy", MWR);
      tick(); ex("st_fetch", F_RDY);
      opcode = OP_BR;
      tick(); ex("br_decode", DEC);
      tick(); alu_cond = 1'b1; ex("br_taken", BR1);
      tick(); ex("br_fetch", F_RDY);
      tick(); ex("br2_decode", DEC);
      tick(); alu_cond = 1'b0; ex("br_not_taken", BR0);
      alu_cond = 1'b1; ex("br_cond_follow", BR1);
      alu_cond = 1'b0;
      tick(); ex("br2_fetch", F_RDY);
      opcode = OP_JAL;
      tick(); ex("jal_decode", DEC);
      tick(); ex("jal", JALV);
      tick(); ex("jal_fetch", F_RDY);
      opcode = 7'b1111111;
      tick(); ex("ill_decode", DEC_ILL);
      tick(); ex("ill_fetch", F_RDY);
      opcode = OP_I;
      tick(); ex("i_decode", DEC);
      tick(); ex("i_exec", EXI);
      tick(); ex("i_wb", WBA);
      tick(); ex("i_fetch", F_RDY);
      opcode = OP_LD;
      tick(); ex("rl_decode", DEC);
      tick(); mem_ready = 1'b0; ex("rl_addr", ADR);
      tick(); ex("rl_mem", MRD);
      rst = 1'b1;
      ex("rst_mid_access", ZERO);
      tick(); ex("rst_held", ZERO);
      rst = 1'b0; mem_ready = 1'b1;
      ex("rst_release_idle", ZERO);
      tick(); ex("rst_fresh_fetch", F_RDY);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
